// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. Holds the architectural PC, issues one word-addressed
// request at a time to instruction memory, buffers the returned instructions in
// a small FIFO and hands them to decode over a valid/ready pair. A taken branch
// from Execute (redirect / redirect_pc) reloads the PC, flushes the FIFO and
// marks any in-flight response to be dropped.
//
// Ports:
//   clk, rst_n              clock and synchronous active-low reset
//   imem_req/imem_addr      fetch request (address = current PC), held until gnt
//   imem_gnt                memory accepts the request this cycle
//   imem_rvalid/imem_rdata  in-order response, latency >= 1 cycle
//   redirect/redirect_pc    taken branch and its target from Execute
//   inst_valid/inst_ready   FIFO head handshake to decode
//   inst/inst_pc            head instruction and the address it came from
//
// Optional feature (macro FETCH_PERF_CNT_EN):
//   perf_fetched   counts FIFO pushes
//   perf_squashed  counts dropped responses plus FIFO entries flushed by redirect
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter int             PCW        = 32,
   parameter int             INSTW      = 32,
   parameter int             IBUF_DEPTH = 2,
   parameter logic [PCW-1:0] RESET_PC   = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             imem_req,
   output logic [PCW-1:0]   imem_addr,
   input  logic             imem_gnt,
   input  logic             imem_rvalid,
   input  logic [INSTW-1:0] imem_rdata,
   input  logic             redirect,
   input  logic [PCW-1:0]   redirect_pc,
   output logic             inst_valid,
   input  logic             inst_ready,
   output logic [INSTW-1:0] inst,
   output logic [PCW-1:0]   inst_pc
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]      perf_fetched,
   output logic [31:0]      perf_squashed
`endif
);

   localparam int PTRW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
   localparam int CNTW = PTRW + 1;

   logic [PCW-1:0]   pc_q, pc_d;
   logic [PCW-1:0]   req_pc_q, req_pc_d;
   logic             outstanding_q, outstanding_d;
   logic             discard_q, discard_d;
   logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0]  count_q, count_d;

   // Tiny buffer: storage is read asynchronously at the head pointer.
   logic [INSTW-1:0] ibuf_inst_q [IBUF_DEPTH];
   logic [PCW-1:0]   ibuf_pc_q   [IBUF_DEPTH];

   logic accept;
   logic resp;
   logic push;
   logic pop;

   // Credit rule fifo_count + outstanding < IBUF_DEPTH together with
   // outstanding == 0 reduces to count_q < IBUF_DEPTH.
   assign imem_req   = rst_n && !redirect && !outstanding_q &&
                       (count_q < CNTW'(IBUF_DEPTH));
   assign imem_addr  = pc_q;
   assign inst_valid = rst_n && (count_q != '0);
   assign inst       = inst_valid ? ibuf_inst_q[rd_ptr_q] : '0;
   assign inst_pc    = inst_valid ? ibuf_pc_q[rd_ptr_q]   : '0;

   assign accept = imem_req && imem_gnt;
   assign resp   = imem_rvalid && outstanding_q;
   // A response coinciding with a redirect is wrong-path and never stored.
   assign push   = resp && !discard_q && !redirect;
   assign pop    = inst_valid && inst_ready && !redirect;

   always_comb begin
      pc_d          = pc_q;
      req_pc_d      = req_pc_q;
      outstanding_d = outstanding_q;
      discard_d     = discard_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;

      if (accept) begin
         outstanding_d = 1'b1;
         req_pc_d      = pc_q;
         pc_d          = pc_q + PCW'(1);
      end

      if (resp) begin
         outstanding_d = 1'b0;
         discard_d     = 1'b0;
      end

      if (push) begin
         wr_ptr_d = wr_ptr_q + PTRW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTRW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNTW'(1);
         2'b01:   count_d = count_q - CNTW'(1);
         default: count_d = count_q;
      endcase

      // Redirect overrides everything else this cycle. A request still in
      // flight (not answered this cycle) must have its response dropped.
      if (redirect) begin
         pc_d          = redirect_pc;
         wr_ptr_d      = '0;
         rd_ptr_d      = '0;
         count_d       = '0;
         outstanding_d = outstanding_q && !imem_rvalid;
         discard_d     = outstanding_q && !imem_rvalid;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q          <= RESET_PC;
         req_pc_q      <= RESET_PC;
         outstanding_q <= 1'b0;
         discard_q     <= 1'b0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
      end else begin
         pc_q          <= pc_d;
         req_pc_q      <= req_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
      end
   end

   // Storage needs no reset: the count and pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         ibuf_inst_q[wr_ptr_q] <= imem_rdata;
         ibuf_pc_q[wr_ptr_q]   <= req_pc_q;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched_q, perf_fetched_d;
   logic [31:0] perf_squashed_q, perf_squashed_d;

   always_comb begin
      perf_fetched_d  = perf_fetched_q + 32'(push);
      // Dropped response (discard or redirect) plus whatever the flush removes.
      perf_squashed_d = perf_squashed_q + 32'(resp && (discard_q || redirect)) +
                        (redirect ? 32'(count_q) : 32'd0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_fetched_q  <= '0;
         perf_squashed_q <= '0;
      end else begin
         perf_fetched_q  <= perf_fetched_d;
         perf_squashed_q <= perf_squashed_d;
      end
   end

   assign perf_fetched  = perf_fetched_q;
   assign perf_squashed = perf_squashed_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Bench for fetch_unit. A behavioural instruction memory answers each granted
// request after mem_lat cycles with 0xA000_0000 | addr. Expected FIFO entries
// are pushed to a scoreboard queue when the memory returns a response that a
// correct fetch unit must keep, and are popped and compared when decode takes
// an instruction. A model PC tracks what imem_addr must be.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_unit;

   localparam int          PCW        = 32;
   localparam int          INSTW      = 32;
   localparam int          IBUF_DEPTH = 2;
   localparam logic [31:0] RESET_PC   = 32'h0;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             imem_req;
   logic [PCW-1:0]   imem_addr;
   logic             imem_gnt;
   logic             imem_rvalid;
   logic [INSTW-1:0] imem_rdata;
   logic             redirect;
   logic [PCW-1:0]   redirect_pc;
   logic             inst_valid;
   logic             inst_ready;
   logic [INSTW-1:0] inst;
   logic [PCW-1:0]   inst_pc;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0]      perf_fetched;
   logic [31:0]      perf_squashed;
`endif

   fetch_unit #(
      .PCW        (PCW),
      .INSTW      (INSTW),
      .IBUF_DEPTH (IBUF_DEPTH),
      .RESET_PC   (RESET_PC)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .inst        (inst),
      .inst_pc     (inst_pc)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetched  (perf_fetched),
      .perf_squashed (perf_squashed)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } ent_t;

   int          n_checks = 0;
   int          n_pass   = 0;

   ent_t        sb[$];
   logic [31:0] popped[$];

   logic [31:0] exp_pc;
   bit          pend;
   bit          pend_keep;
   logic [31:0] pend_bus_addr;
   logic [31:0] pend_exp_pc;
   int          pend_wait;
   int          mem_lat = 1;
   bit          acc_now;
   logic [31:0] acc_addr;

   // One clock cycle: sample outputs, update scoreboard and memory model,
   // cross the rising edge, then drive the memory response for the next cycle.
   task automatic step();
      ent_t e;
      bit   req_exp;
      bit   resp_now;
      #1;
      acc_now  = 0;
      resp_now = imem_rvalid;
      if (!rst_n) begin
         n_checks++;
         if (imem_req !== 1'b0) $display("FAIL rst_req: imem_req=%b want 0", imem_req);
         else n_pass++;
         n_checks++;
         if (inst_valid !== 1'b0) $display("FAIL rst_valid: inst_valid=%b want 0", inst_valid);
         else n_pass++;
         sb.delete();
         pend   = 0;
         exp_pc = RESET_PC;
      end else begin
         req_exp = !redirect && !pend && ((sb.size() + int'(pend)) < IBUF_DEPTH);
         n_checks++;
         if (imem_req !== req_exp) $display("FAIL req: imem_req=%b want %b", imem_req, req_exp);
         else n_pass++;
         if (req_exp) begin
            n_checks++;
            if (imem_addr !== exp_pc) $display("FAIL addr: imem_addr=%h want %h", imem_addr, exp_pc);
            else n_pass++;
         end
         n_checks++;
         if (inst_valid !== (sb.size() != 0))
            $display("FAIL valid: inst_valid=%b want %b", inst_valid, sb.size() != 0);
         else n_pass++;

         if (redirect) begin
            sb.delete();
            pend_keep = 0;
            exp_pc    = redirect_pc;
         end else begin
            if (inst_valid && inst_ready && sb.size() != 0) begin
               e = sb.pop_front();
               n_checks++;
               if (inst !== e.inst || inst_pc !== e.pc)
                  $display("FAIL pop: inst=%h pc=%h want inst=%h pc=%h", inst, inst_pc, e.inst, e.pc);
               else n_pass++;
               popped.push_back(inst_pc);
            end
            if (resp_now && pend && pend_keep)
               sb.push_back({32'hA000_0000 | pend_exp_pc, pend_exp_pc});
            if (req_exp && imem_gnt) exp_pc = exp_pc + 32'd1;
         end

         if (resp_now) pend = 0;
         if (imem_req && imem_gnt) begin
            pend          = 1;
            pend_keep     = 1;
            pend_bus_addr = imem_addr;
            pend_exp_pc   = req_exp ? (exp_pc - 32'd1) : imem_addr;
            pend_wait     = mem_lat - 1;
            acc_now       = 1;
            acc_addr      = imem_addr;
         end else if (pend && pend_wait > 0) begin
            pend_wait--;
         end
      end
      @(posedge clk);
      #1;
      imem_rvalid = pend && (pend_wait == 0);
      imem_rdata  = 32'hA000_0000 | pend_bus_addr;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      redirect = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      inst_ready = 1'b0;
      do_reset();
      #1;
      n_checks++;
      if (inst_valid !== 1'b0) $display("FAIL reset_valid: inst_valid=%b want 0", inst_valid);
      else n_pass++;
      n_checks++;
      if (imem_addr !== RESET_PC) $display("FAIL reset_pc: imem_addr=%h want %h", imem_addr, RESET_PC);
      else n_pass++;
      n_checks++;
      if (imem_req !== 1'b1) $display("FAIL reset_req: imem_req=%b want 1", imem_req);
      else n_pass++;
   endtask

   task automatic test_stream();
      inst_ready = 1'b1;
      popped.delete();
      repeat (12) step();
      n_checks++;
      if (popped.size() != 5) $display("FAIL stream_rate: pops=%0d want 5", popped.size());
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (popped.size() <= i || popped[i] !== 32'(i))
            $display("FAIL stream_order%0d: pc=%h want %h", i,
                     (popped.size() > i) ? popped[i] : 32'hx, 32'(i));
         else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      inst_ready = 1'b0;
      do_reset();
      repeat (10) step();
      #1;
      n_checks++;
      if (inst_valid !== 1'b1 || imem_req !== 1'b0 || inst_pc !== 32'h0)
         $display("FAIL bp_full: valid=%b req=%b pc=%h want 1 0 0", inst_valid, imem_req, inst_pc);
      else n_pass++;
      inst_ready = 1'b1;
      popped.delete();
      repeat (8) step();
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (popped.size() <= i || popped[i] !== 32'(i))
            $display("FAIL bp_order%0d: pc=%h want %h", i,
                     (popped.size() > i) ? popped[i] : 32'hx, 32'(i));
         else n_pass++;
      end
   endtask

   task automatic test_redirect_inflight();
      bit found = 0;
      mem_lat    = 2;
      inst_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 200 && !found; i++) begin
         step();
         if (acc_now && acc_addr == 32'h5) found = 1;
      end
      n_checks++;
      if (!found) $display("FAIL rdi_gnt5: grant of addr 5 not seen within budget");
      else n_pass++;
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      step();
      redirect = 1'b0;
      #1;
      n_checks++;
      if (inst_valid !== 1'b0 || imem_addr !== 32'h100)
         $display("FAIL rdi_flush: valid=%b addr=%h want 0 100", inst_valid, imem_addr);
      else n_pass++;
      popped.delete();
      for (int i = 0; i < 50 && popped.size() < 1; i++) step();
      n_checks++;
      if (popped.size() < 1 || popped[0] !== 32'h100)
         $display("FAIL rdi_first: pc=%h want 100", (popped.size() > 0) ? popped[0] : 32'hx);
      else n_pass++;
      mem_lat = 1;
   endtask

   task automatic test_redirect_coincident();
      bit found = 0;
      mem_lat    = 1;
      inst_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 200 && !found; i++) begin
         step();
         if (acc_now && acc_addr == 32'h7) found = 1;
      end
      n_checks++;
      if (!found) $display("FAIL rdc_gnt7: grant of addr 7 not seen within budget");
      else n_pass++;
      // Next cycle carries the response for addr 7 together with the redirect.
      redirect    = 1'b1;
      redirect_pc = 32'h40;
      step();
      redirect = 1'b0;
      popped.delete();
      for (int i = 0; i < 50 && popped.size() < 2; i++) step();
      n_checks++;
      if (popped.size() < 2 || popped[0] !== 32'h40 || popped[1] !== 32'h41)
         $display("FAIL rdc_order: pcs=%h,%h want 40,41",
                  (popped.size() > 0) ? popped[0] : 32'hx,
                  (popped.size() > 1) ? popped[1] : 32'hx);
      else n_pass++;
   endtask

   task automatic test_pc_wrap();
      inst_ready  = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFF;
      step();
      redirect = 1'b0;
      popped.delete();
      for (int i = 0; i < 50 && popped.size() < 2; i++) step();
      n_checks++;
      if (popped.size() < 2 || popped[0] !== 32'hFFFF_FFFF || popped[1] !== 32'h0)
         $display("FAIL wrap: pcs=%h,%h want ffffffff,00000000",
                  (popped.size() > 0) ? popped[0] : 32'hx,
                  (popped.size() > 1) ? popped[1] : 32'hx);
      else n_pass++;
   endtask

   task automatic test_mid_reset();
      bit found = 0;
      mem_lat    = 3;
      inst_ready = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         step();
         if (sb.size() == 1 && pend) found = 1;
      end
      n_checks++;
      if (!found) $display("FAIL mr_setup: buffered entry with request in flight not reached");
      else n_pass++;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b0)
         $display("FAIL mr_during: req=%b valid=%b want 0 0", imem_req, inst_valid);
      else n_pass++;
      step();
      rst_n   = 1'b1;
      mem_lat = 1;
      #1;
      n_checks++;
      if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RESET_PC)
         $display("FAIL mr_after: valid=%b req=%b addr=%h want 0 1 %h",
                  inst_valid, imem_req, imem_addr, RESET_PC);
      else n_pass++;
`ifdef FETCH_PERF_CNT_EN
      n_checks++;
      if (perf_fetched !== 32'd0 || perf_squashed !== 32'd0)
         $display("FAIL mr_perf: fetched=%0d squashed=%0d want 0 0", perf_fetched, perf_squashed);
      else n_pass++;
`endif
      inst_ready = 1'b1;
      popped.delete();
      for (int i = 0; i < 50 && popped.size() < 2; i++) step();
      n_checks++;
      if (popped.size() < 2 || popped[0] !== RESET_PC || popped[1] !== RESET_PC + 32'd1)
         $display("FAIL mr_restart: pcs=%h,%h want %h,%h",
                  (popped.size() > 0) ? popped[0] : 32'hx,
                  (popped.size() > 1) ? popped[1] : 32'hx, RESET_PC, RESET_PC + 32'd1);
      else n_pass++;
   endtask

   initial begin
      rst_n         = 1'b0;
      imem_gnt      = 1'b1;
      imem_rvalid   = 1'b0;
      imem_rdata    = '0;
      redirect      = 1'b0;
      redirect_pc   = '0;
      inst_ready    = 1'b0;
      exp_pc        = RESET_PC;
      pend          = 0;
      pend_keep     = 0;
      pend_bus_addr = '0;
      pend_exp_pc   = '0;
      pend_wait     = 0;
      acc_now       = 0;
      acc_addr      = '0;

      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_inflight();
      test_redirect_coincident();
      test_pc_wrap();
      test_mid_reset();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
